// File: rtl/duty_scan_pkg.sv
// Shared types and helpers for the duty/period scan controller.
// Optional continuous-scan mode is enabled by defining DUTY_SCAN_CONT_EN.
package duty_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ARM,
        MEAS,
        EMIT
    } state_e;

    localparam int SAT_W = 64;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Adds a and b and clamps the sum at the all-ones value of a w-bit field (w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] lim;
        lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/duty_scan_ctrl_sig_sync_edge.sv
// Two-flop synchronizer for one asynchronous input bit.
// Edge detection lives in the controller so its history can be reloaded on a channel switch.
module sig_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = sig_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sig_out = sync_q;

endmodule

// File: rtl/duty_scan_ctrl.sv
// Scan scheduler sharing one high-time/period measurement datapath across NCH inputs.
// Define DUTY_SCAN_CONT_EN to add the 'cont' input that restarts the scan after each pass.
module duty_scan_ctrl
    import duty_scan_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = 32,
    parameter int NPER    = 4,
    parameter int TIMEOUT = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        sig,
    input  logic                  start,
    input  logic [NCH-1:0]        ch_mask,
`ifdef DUTY_SCAN_CONT_EN
    input  logic                  cont,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ch_w(NCH)-1:0]  res_ch,
    output logic [CW-1:0]         res_high,
    output logic [CW-1:0]         res_period,
    output logic                  res_tmo
);

    localparam int CH_W = ch_w(NCH);
    localparam int PS_W = (NPER > 1) ? $clog2(NPER) : 1;
    localparam int TM_W = $clog2(TIMEOUT);

    logic [NCH-1:0] sync;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        sig_sync_edge u_sync (
            .clk    (clk),
            .reset  (reset),
            .sig_in (sig[i]),
            .sig_out(sync[i])
        );
    end

    state_e          state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
`ifdef DUTY_SCAN_CONT_EN
    logic [NCH-1:0]  orig_mask_q, orig_mask_d;
`endif
    logic [CH_W-1:0] idx_q, idx_d;
    logic            prev_q, prev_d;
    logic [TM_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [PS_W-1:0] per_seen_q, per_seen_d;
    logic [CW-1:0]   period_q, period_d;
    logic [CW-1:0]   high_q, high_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            res_valid_q, res_valid_d;
    logic            res_tmo_q, res_tmo_d;
    logic [CH_W-1:0] res_ch_q, res_ch_d;
    logic [CW-1:0]   res_high_q, res_high_d;
    logic [CW-1:0]   res_period_q, res_period_d;

    logic            s;
    logic            rise;
    logic            tmo_hit;
    logic            next_found;
    logic [CH_W-1:0] next_idx;

    assign s       = sync[idx_q];
    assign rise    = s & ~prev_q;
    assign tmo_hit = (tmo_cnt_q == TM_W'(TIMEOUT - 1));

    // Accepted channels are cleared from mask_q, so the lowest remaining bit is also the lowest at or above idx_q.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                next_found = 1'b1;
                next_idx   = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
`ifdef DUTY_SCAN_CONT_EN
        orig_mask_d  = orig_mask_q;
`endif
        idx_d        = idx_q;
        prev_d       = s;
        tmo_cnt_d    = tmo_cnt_q;
        per_seen_d   = per_seen_q;
        period_d     = period_q;
        high_d       = high_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        res_valid_d  = res_valid_q;
        res_tmo_d    = res_tmo_q;
        res_ch_d     = res_ch_q;
        res_high_d   = res_high_q;
        res_period_d = res_period_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = ch_mask;
`ifdef DUTY_SCAN_CONT_EN
                    orig_mask_d = ch_mask;
`endif
                    busy_d  = 1'b1;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (next_found) begin
                    idx_d     = next_idx;
                    prev_d    = sync[next_idx];
                    tmo_cnt_d = '0;
                    state_d   = ARM;
                end else begin
                    done_d = 1'b1;
`ifdef DUTY_SCAN_CONT_EN
                    if (cont) begin
                        mask_d = orig_mask_q;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
            ARM, MEAS: begin
                if (tmo_hit) begin
                    state_d      = EMIT;
                    res_valid_d  = 1'b1;
                    res_tmo_d    = 1'b1;
                    res_ch_d     = idx_q;
                    res_high_d   = '0;
                    res_period_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TM_W'(1);
                    if (state_q == ARM) begin
                        if (rise) begin
                            period_d   = CW'(1);
                            high_d     = CW'(1);
                            per_seen_d = '0;
                            state_d    = MEAS;
                        end
                    end else if (rise && (per_seen_q == PS_W'(NPER - 1))) begin
                        state_d      = EMIT;
                        res_valid_d  = 1'b1;
                        res_tmo_d    = 1'b0;
                        res_ch_d     = idx_q;
                        res_high_d   = high_q;
                        res_period_d = period_q;
                    end else begin
                        if (rise) begin
                            per_seen_d = per_seen_q + PS_W'(1);
                        end
                        period_d = CW'(sat_add(SAT_W'(period_q), SAT_W'(1), CW));
                        high_d   = CW'(sat_add(SAT_W'(high_q), SAT_W'(s), CW));
                    end
                end
            end
            EMIT: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    mask_d[idx_q] = 1'b0;
                    state_d       = SEL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mask_q       <= '0;
`ifdef DUTY_SCAN_CONT_EN
            orig_mask_q  <= '0;
`endif
            idx_q        <= '0;
            prev_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            per_seen_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_tmo_q    <= 1'b0;
            res_ch_q     <= '0;
            res_high_q   <= '0;
            res_period_q <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
`ifdef DUTY_SCAN_CONT_EN
            orig_mask_q  <= orig_mask_d;
`endif
            idx_q        <= idx_d;
            prev_q       <= prev_d;
            tmo_cnt_q    <= tmo_cnt_d;
            per_seen_q   <= per_seen_d;
            period_q     <= period_d;
            high_q       <= high_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_tmo_q    <= res_tmo_d;
            res_ch_q     <= res_ch_d;
            res_high_q   <= res_high_d;
            res_period_q <= res_period_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign res_valid  = res_valid_q;
    assign res_tmo    = res_tmo_q;
    assign res_ch     = res_ch_q;
    assign res_high   = res_high_q;
    assign res_period = res_period_q;

endmodule
